id_stage_ctrl: RTL and testbench
================================

# id_stage_ctrl

Decode-stage controller between fetch and execute in the 64-bit RV64I pipeline. Accepts one instruction per handshake from IF, decodes opcode-driven control and the sign-extended immediate, and holds the result in the ID/EX pipeline register under valid/ready flow control with flush support. Tracks a retired-to-EX instruction count and, optionally, halts on illegal opcodes.

## Interface
- `XLEN`, 64, datapath/PC/immediate width
- `CNT_W`, 64, width of the decoded-instruction counter
---
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `if_valid`  in  1  IF presents an instruction
- `if_ready`  out  1  ID accepts this cycle
- `if_pc`  in  XLEN  PC of presented instruction
- `if_inst`  in  32  instruction word
- `flush`  in  1  squash ID/EX contents and any incoming beat
- `ex_valid`  out  1  ID/EX register holds a valid instruction
- `ex_ready`  in  1  EX consumes this cycle
- `ex_pc`  out  XLEN  registered PC
- `ex_inst`  out  32  registered instruction
- `ex_imm`  out  XLEN  registered immediate
- `ex_ctrl`  out  `ctrl_t`  registered control bundle
- `ex_illegal`  out  1  registered illegal-opcode flag
- `dec_count`  out  CNT_W  instructions handed to EX since reset

## Operation
- Accept = `if_valid && if_ready`; handoff = `ex_valid && ex_ready`.
- `if_ready = (state==RUN) && !flush && (!ex_valid || ex_ready)`.
- On accept: register pc, inst, imm, ctrl, illegal; set `ex_valid`. On handoff without accept: clear `ex_valid`. Otherwise hold all ex_* unchanged.
- Immediate by opcode[6:0], sign bit inst[31]: I (0010011, 0011011, 0000011, 1100111) = inst[31:20]; S (0100011) = {inst[31:25],inst[11:7]}; B (1100011) = {inst[31],inst[7],inst[30:25],inst[11:8],0}; J (1101111) = {inst[31],inst[19:12],inst[20],inst[30:21],0}; U (0110111, 0010111) = {inst[31:12],12'b0}; all sign-extended to XLEN. Any other opcode: imm = 0.
- ctrl_t fields: `alu_src_imm`, `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`, `is_word`, `pc_rel`, `wb_sel` (ALU/MEM/PC4/IMM). Opcode 0110011/0111011 set reg_write; loads set mem_read+reg_write+wb_sel=MEM; stores mem_write; jal/jalr jump+reg_write+wb_sel=PC4; lui wb_sel=IMM; auipc pc_rel; *W opcodes is_word.
- FSM: RUN, HALT (HALT reachable only with illegal trap, see Configuration). HALT -> RUN on `flush`.
- `dec_count` += 1 on each handoff; wraps modulo 2^CNT_W.

## Timing
- Latency: accepted beat visible on ex_* the next cycle; throughput 1/cycle when `ex_ready` held high.
- ex_* stable while `ex_valid && !ex_ready` (hold rule, checked by assertion).
- `flush`: next cycle `ex_valid=0`, state=RUN; incoming beat dropped (if_ready already 0); a handoff in the flush cycle still counts.
- Simultaneous handoff and accept: new instruction loaded, `ex_valid` stays 1.
- Reset (any cycle, including mid-stall): state=RUN, `ex_valid=0`, `ex_pc/ex_inst/ex_imm=0`, `ex_ctrl='0`, `ex_illegal=0`, `dec_count=0`; reset dominates flush.

## Configuration
- `ID_ILLEGAL_TRAP_EN` defined: opcode outside the decoded set sets `ex_illegal=1`, ctrl all zero; on its accept FSM enters HALT, `if_ready=0` until `flush`.
- Undefined: unknown opcode passes as NOP (ctrl zero, imm 0), `ex_illegal` tied 0, FSM never leaves RUN.

## Structure
- Package `id_pkg`: `ctrl_t` packed struct, `wb_sel_t` enum, opcode localparams, `state_t`.
- Sub-module `id_decoder`: purely combinational inst -> {imm, ctrl, illegal}; `id_stage_ctrl` owns handshake, register, FSM, counter.

## Test plan
- `addi x1,x0,-1` (0xFFF00093), pc 0x80000000, ex_ready=1 -> next cycle ex_imm=0xFFFFFFFFFFFFFFFF, alu_src_imm=1, reg_write=1, dec_count 0->1 on handoff.
- `beq x0,x0,-4` (0xFE000EE3) -> ex_imm=0xFFFFFFFFFFFFFFFC, branch=1; `lui x1,0x80000` (0x800000B7) -> ex_imm=0xFFFFFFFF80000000, wb_sel=IMM.
- Back-pressure: two beats, ex_ready=0 for 3 cycles -> if_ready=0 after first, ex_* frozen; release -> second beat follows next cycle, dec_count=2.
- Flush with if_valid=1 and ex_valid=1, ex_ready=0 -> next cycle ex_valid=0, beat not accepted, dec_count unchanged.
- Opcode 0x0000007F with trap enabled -> ex_illegal=1, if_ready=0 until flush; disabled -> ex_illegal=0, ctrl zero, flow continues.
- Reset asserted while stalled with ex_valid=1 -> next cycle all outputs at reset values, if_ready=1.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types and opcode constants for the RV64I decode stage.
package id_pkg;

   // Write-back source selector.
   typedef enum logic [1:0] {
      WbAlu = 2'd0,
      WbMem = 2'd1,
      WbPc4 = 2'd2,
      WbImm = 2'd3
   } wb_sel_t;

   // Control bundle carried in the ID/EX register.
   typedef struct packed {
      logic    alu_src_imm;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    jump;
      logic    is_word;
      logic    pc_rel;
      wb_sel_t wb_sel;
   } ctrl_t;

   typedef enum logic {
      StRun  = 1'b0,
      StHalt = 1'b1
   } state_t;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpImm32  = 7'b0011011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpReg32  = 7'b0111011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpJal    = 7'b1101111;

endpackage

// File: rtl/id_stage_ctrl_if.sv
// IF->ID->EX handshake bundle. The slave modport is the decode stage,
// the master modport is whatever drives fetch and consumes execute.
interface id_stage_ctrl_if
   import id_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 64
) ();

   logic              if_valid;
   logic              if_ready;
   logic [XLEN-1:0]   if_pc;
   logic [31:0]       if_inst;
   logic              flush;
   logic              ex_valid;
   logic              ex_ready;
   logic [XLEN-1:0]   ex_pc;
   logic [31:0]       ex_inst;
   logic [XLEN-1:0]   ex_imm;
   ctrl_t             ex_ctrl;
   logic              ex_illegal;
   logic [CNT_W-1:0]  dec_count;

   modport slave (
      input  if_valid, if_pc, if_inst, flush, ex_ready,
      output if_ready, ex_valid, ex_pc, ex_inst, ex_imm, ex_ctrl, ex_illegal, dec_count
   );

   modport master (
      output if_valid, if_pc, if_inst, flush, ex_ready,
      input  if_ready, ex_valid, ex_pc, ex_inst, ex_imm, ex_ctrl, ex_illegal, dec_count
   );

endinterface

// File: rtl/id_decoder.sv
// Combinational RV64I decoder: instruction word -> immediate, control, unknown-opcode flag.
module id_decoder
   import id_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [31:0]     inst_i,
   output logic [XLEN-1:0] imm_o,
   output ctrl_t           ctrl_o,
   output logic            illegal_o
);

   logic [6:0]  opcode;
   logic [11:0] imm_i;
   logic [11:0] imm_s;
   logic [12:0] imm_b;
   logic [20:0] imm_j;
   logic [31:0] imm_u;

   assign opcode = inst_i[6:0];
   assign imm_i  = inst_i[31:20];
   assign imm_s  = {inst_i[31:25], inst_i[11:7]};
   assign imm_b  = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_j  = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
   assign imm_u  = {inst_i[31:12], 12'b0};

   // Opcode decode; unknown opcodes yield zero control and zero immediate.
   always_comb begin
      imm_o     = '0;
      ctrl_o    = '0;
      illegal_o = 1'b0;
      unique case (opcode)
         OpImm, OpImm32: begin
            imm_o              = {{(XLEN-12){imm_i[11]}}, imm_i};
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.reg_write   = 1'b1;
            ctrl_o.is_word     = (opcode == OpImm32);
         end
         OpReg, OpReg32: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.is_word   = (opcode == OpReg32);
         end
         OpLoad: begin
            imm_o              = {{(XLEN-12){imm_i[11]}}, imm_i};
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.mem_read    = 1'b1;
            ctrl_o.reg_write   = 1'b1;
            ctrl_o.wb_sel      = WbMem;
         end
         OpStore: begin
            imm_o              = {{(XLEN-12){imm_s[11]}}, imm_s};
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.mem_write   = 1'b1;
         end
         OpBranch: begin
            imm_o         = {{(XLEN-13){imm_b[12]}}, imm_b};
            ctrl_o.branch = 1'b1;
         end
         OpJal: begin
            imm_o            = {{(XLEN-21){imm_j[20]}}, imm_j};
            ctrl_o.jump      = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wb_sel    = WbPc4;
         end
         OpJalr: begin
            imm_o              = {{(XLEN-12){imm_i[11]}}, imm_i};
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.jump        = 1'b1;
            ctrl_o.reg_write   = 1'b1;
            ctrl_o.wb_sel      = WbPc4;
         end
         OpLui: begin
            imm_o            = {{(XLEN-32){imm_u[31]}}, imm_u};
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wb_sel    = WbImm;
         end
         OpAuipc: begin
            imm_o              = {{(XLEN-32){imm_u[31]}}, imm_u};
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.reg_write   = 1'b1;
            ctrl_o.pc_rel      = 1'b1;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: IF handshake, ID/EX pipeline register, run/halt FSM,
// handed-off instruction counter. Define ID_ILLEGAL_TRAP_EN to flag unknown
// opcodes and halt intake until flush; otherwise they pass through as NOPs.
module id_stage_ctrl
   import id_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 64
) (
   input logic              clk,
   input logic              reset,
   id_stage_ctrl_if.slave   bus
);

`ifdef ID_ILLEGAL_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   state_t           state_q, state_d;
   logic             ex_valid_q, ex_valid_d;
   logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
   logic [31:0]      ex_inst_q, ex_inst_d;
   logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
   ctrl_t            ex_ctrl_q, ex_ctrl_d;
   logic             ex_illegal_q, ex_illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  dec_imm;
   ctrl_t            dec_ctrl;
   logic             dec_illegal;
   logic             if_ready;
   logic             accept;
   logic             handoff;

   id_decoder #(
      .XLEN (XLEN)
   ) u_decoder (
      .inst_i    (bus.if_inst),
      .imm_o     (dec_imm),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_illegal)
   );

   assign if_ready = (state_q == StRun) && !bus.flush && (!ex_valid_q || bus.ex_ready);
   assign accept   = bus.if_valid && if_ready;
   assign handoff  = ex_valid_q && bus.ex_ready;

   // Next-state for the pipeline register, FSM and counter; flush beats everything but reset.
   always_comb begin
      state_d      = state_q;
      ex_valid_d   = ex_valid_q;
      ex_pc_d      = ex_pc_q;
      ex_inst_d    = ex_inst_q;
      ex_imm_d     = ex_imm_q;
      ex_ctrl_d    = ex_ctrl_q;
      ex_illegal_d = ex_illegal_q;
      cnt_d        = cnt_q;

      // A handoff in a flush cycle still counts.
      if (handoff) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (bus.flush) begin
         ex_valid_d = 1'b0;
         state_d    = StRun;
      end else if (accept) begin
         ex_valid_d   = 1'b1;
         ex_pc_d      = bus.if_pc;
         ex_inst_d    = bus.if_inst;
         ex_imm_d     = dec_imm;
         ex_ctrl_d    = dec_ctrl;
         ex_illegal_d = TrapEn && dec_illegal;
         if (TrapEn && dec_illegal) begin
            state_d = StHalt;
         end
      end else if (handoff) begin
         ex_valid_d = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StRun;
         ex_valid_q   <= 1'b0;
         ex_pc_q      <= '0;
         ex_inst_q    <= '0;
         ex_imm_q     <= '0;
         ex_ctrl_q    <= '0;
         ex_illegal_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         ex_valid_q   <= ex_valid_d;
         ex_pc_q      <= ex_pc_d;
         ex_inst_q    <= ex_inst_d;
         ex_imm_q     <= ex_imm_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_illegal_q <= ex_illegal_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.if_ready   = if_ready;
   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_pc      = ex_pc_q;
   assign bus.ex_inst    = ex_inst_q;
   assign bus.ex_imm     = ex_imm_q;
   assign bus.ex_ctrl    = ex_ctrl_q;
   assign bus.ex_illegal = ex_illegal_q;
   assign bus.dec_count  = cnt_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl, plus a monitor for the ex_* hold rule.
module tb_id_stage_ctrl;
   import id_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   id_stage_ctrl_if #(.XLEN(64), .CNT_W(64)) bus ();

   id_stage_ctrl #(
      .XLEN  (64),
      .CNT_W (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold rule: a stalled, valid ID/EX register must not change.
   logic        hold_pend;
   logic [63:0] h_pc, h_imm;
   logic [31:0] h_inst;
   ctrl_t       h_ctrl;
   logic        h_ill;
   initial hold_pend = 1'b0;
   always @(negedge clk) begin
      if (hold_pend) begin
         check("hold_valid", 64'(bus.ex_valid), 64'd1);
         check("hold_pc", bus.ex_pc, h_pc);
         check("hold_inst", 64'(bus.ex_inst), 64'(h_inst));
         check("hold_imm", bus.ex_imm, h_imm);
         check("hold_ctrl", 64'(bus.ex_ctrl), 64'(h_ctrl));
         check("hold_ill", 64'(bus.ex_illegal), 64'(h_ill));
      end
      hold_pend = (bus.ex_valid === 1'b1) && (bus.ex_ready === 1'b0) &&
                  (bus.flush === 1'b0) && (reset === 1'b0);
      h_pc   = bus.ex_pc;
      h_imm  = bus.ex_imm;
      h_inst = bus.ex_inst;
      h_ctrl = bus.ex_ctrl;
      h_ill  = bus.ex_illegal;
   end

   ctrl_t exp_ctrl;
   logic  exp_ill;

   initial begin
      checks   = 0;
      failures = 0;
`ifdef ID_ILLEGAL_TRAP_EN
      exp_ill = 1'b1;
`else
      exp_ill = 1'b0;
`endif
      reset        = 1'b1;
      bus.if_valid = 1'b0;
      bus.if_pc    = '0;
      bus.if_inst  = '0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 64'(bus.ex_valid), 64'd0);
      check("rst_pc", bus.ex_pc, 64'd0);
      check("rst_imm", bus.ex_imm, 64'd0);
      check("rst_ctrl", 64'(bus.ex_ctrl), 64'd0);
      check("rst_cnt", bus.dec_count, 64'd0);
      reset = 1'b0;
      #1;
      check("rst_if_ready", 64'(bus.if_ready), 64'd1);

      // addi x1,x0,-1
      bus.if_valid = 1'b1;
      bus.if_pc    = 64'h8000_0000;
      bus.if_inst  = 32'hFFF0_0093;
      bus.ex_ready = 1'b1;
      tick();
      bus.if_valid = 1'b0;
      exp_ctrl = '0;
      exp_ctrl.alu_src_imm = 1'b1;
      exp_ctrl.reg_write   = 1'b1;
      check("addi_valid", 64'(bus.ex_valid), 64'd1);
      check("addi_pc", bus.ex_pc, 64'h8000_0000);
      check("addi_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_ctrl", 64'(bus.ex_ctrl), 64'(exp_ctrl));
      check("addi_cnt0", bus.dec_count, 64'd0);
      tick();
      check("addi_cnt1", bus.dec_count, 64'd1);
      check("addi_gone", 64'(bus.ex_valid), 64'd0);

      // beq x0,x0,-4 followed back-to-back by lui x1,0x80000
      bus.if_valid = 1'b1;
      bus.if_pc    = 64'h8000_0004;
      bus.if_inst  = 32'hFE00_0EE3;
      tick();
      exp_ctrl = '0;
      exp_ctrl.branch = 1'b1;
      check("beq_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      check("beq_ctrl", 64'(bus.ex_ctrl), 64'(exp_ctrl));
      bus.if_pc   = 64'h8000_0008;
      bus.if_inst = 32'h8000_00B7;
      tick();
      bus.if_valid = 1'b0;
      exp_ctrl = '0;
      exp_ctrl.reg_write = 1'b1;
      exp_ctrl.wb_sel    = WbImm;
      check("lui_valid", 64'(bus.ex_valid), 64'd1);
      check("lui_imm", bus.ex_imm, 64'hFFFF_FFFF_8000_0000);
      check("lui_ctrl", 64'(bus.ex_ctrl), 64'(exp_ctrl));
      check("lui_cnt", bus.dec_count, 64'd2);
      tick();
      check("lui_cnt_after", bus.dec_count, 64'd3);

      // Back-pressure: beat A accepted, beat B waits three stalled cycles.
      bus.ex_ready = 1'b0;
      bus.if_valid = 1'b1;
      bus.if_pc    = 64'h100;
      bus.if_inst  = 32'h0050_0113;
      tick();
      bus.if_pc    = 64'h104;
      bus.if_inst  = 32'h00A0_0193;
      for (int i = 0; i < 3; i++) begin
         check("bp_if_ready", 64'(bus.if_ready), 64'd0);
         check("bp_pc", bus.ex_pc, 64'h100);
         check("bp_imm", bus.ex_imm, 64'd5);
         tick();
      end
      bus.ex_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(bus.if_ready), 64'd1);
      tick();
      bus.if_valid = 1'b0;
      check("bp_b_pc", bus.ex_pc, 64'h104);
      check("bp_b_imm", bus.ex_imm, 64'd10);
      check("bp_cnt", bus.dec_count, 64'd4);
      tick();
      check("bp_cnt_after", bus.dec_count, 64'd5);

      // Flush while stalled with a new beat offered.
      bus.ex_ready = 1'b0;
      bus.if_valid = 1'b1;
      bus.if_pc    = 64'h200;
      bus.if_inst  = 32'h0010_0093;
      tick();
      bus.if_pc    = 64'h204;
      bus.if_inst  = 32'h0020_0093;
      bus.flush    = 1'b1;
      #1;
      check("fl_if_ready", 64'(bus.if_ready), 64'd0);
      tick();
      bus.flush    = 1'b0;
      bus.if_valid = 1'b0;
      check("fl_valid", 64'(bus.ex_valid), 64'd0);
      check("fl_cnt", bus.dec_count, 64'd5);
      #1;
      check("fl_if_ready_after", 64'(bus.if_ready), 64'd1);

      // Flush coinciding with a handoff: the handoff still counts.
      bus.if_valid = 1'b1;
      bus.if_pc    = 64'h208;
      bus.if_inst  = 32'h0030_0093;
      tick();
      bus.if_valid = 1'b0;
      bus.ex_ready = 1'b1;
      bus.flush    = 1'b1;
      tick();
      bus.flush    = 1'b0;
      check("flh_valid", 64'(bus.ex_valid), 64'd0);
      check("flh_cnt", bus.dec_count, 64'd6);

      // Unknown opcode 0x7F.
      bus.ex_ready = 1'b0;
      bus.if_valid = 1'b1;
      bus.if_pc    = 64'h400;
      bus.if_inst  = 32'h0000_007F;
      tick();
      bus.if_valid = 1'b0;
      check("ill_valid", 64'(bus.ex_valid), 64'd1);
      check("ill_flag", 64'(bus.ex_illegal), 64'(exp_ill));
      check("ill_ctrl", 64'(bus.ex_ctrl), 64'd0);
      check("ill_imm", bus.ex_imm, 64'd0);
      bus.ex_ready = 1'b1;
      #1;
      check("ill_if_ready", 64'(bus.if_ready), 64'(!exp_ill));
      tick();
      check("ill_cnt", bus.dec_count, 64'd7);
      check("ill_if_ready2", 64'(bus.if_ready), 64'(!exp_ill));
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      check("ill_flush_ready", 64'(bus.if_ready), 64'd1);

      // Reset while stalled with a valid instruction.
      bus.ex_ready = 1'b0;
      bus.if_valid = 1'b1;
      bus.if_pc    = 64'h300;
      bus.if_inst  = 32'h0050_0113;
      tick();
      bus.if_valid = 1'b0;
      check("rs_valid_pre", 64'(bus.ex_valid), 64'd1);
      reset = 1'b1;
      tick();
      check("rs_valid", 64'(bus.ex_valid), 64'd0);
      check("rs_pc", bus.ex_pc, 64'd0);
      check("rs_inst", 64'(bus.ex_inst), 64'd0);
      check("rs_imm", bus.ex_imm, 64'd0);
      check("rs_ctrl", 64'(bus.ex_ctrl), 64'd0);
      check("rs_ill", 64'(bus.ex_illegal), 64'd0);
      check("rs_cnt", bus.dec_count, 64'd0);
      reset = 1'b0;
      #1;
      check("rs_if_ready", 64'(bus.if_ready), 64'd1);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
